// File: rtl/imm_enc_pkg.sv
// Shared types and constants for the immediate encoder.
package imm_enc_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_MISAL   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  immsrc;
        logic [31:0] imm;
        logic [31:0] base;
    } enc_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  errcode;
    } enc_rsp_t;

    // True when v survives truncation to n bits followed by sign extension,
    // i.e. every bit from n-1 upward is a copy of the sign bit.
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned n);
        logic [31:0] hi;
        hi = $unsigned($signed(v) >>> (n - 1));
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational range/alignment check and immediate field packing.
module imm_pack
    import imm_enc_pkg::*;
(
    input  enc_req_t req,
    output enc_rsp_t rsp
);

    logic [31:0] imm;
    logic [31:0] pk;
    logic        rng_ok;
    logic        misal;
    logic        illegal;
    logic [1:0]  ec;

    assign imm = req.imm;

    // Classify the request: immediate fits its field, is aligned, format legal
    always_comb begin
        rng_ok  = 1'b1;
        misal   = 1'b0;
        illegal = 1'b0;
        case (req.immsrc)
            IMM_I, IMM_S: rng_ok = sext_fits(imm, 12);
            IMM_B: begin
                rng_ok = sext_fits(imm, 13);
                misal  = imm[0];
            end
            IMM_J: begin
                rng_ok = sext_fits(imm, 21);
                misal  = imm[0];
            end
            IMM_U:   rng_ok  = (imm[11:0] == 12'h000);
            default: illegal = 1'b1;
        endcase
    end

    // Scatter immediate bits into the base word; non-immediate fields pass through
    always_comb begin
        pk = req.base;
        case (req.immsrc)
            IMM_I: pk[31:20] = imm[11:0];
            IMM_S: begin
                pk[31:25] = imm[11:5];
                pk[11:7]  = imm[4:0];
            end
            IMM_B: begin
                pk[31]    = imm[12];
                pk[30:25] = imm[10:5];
                pk[11:8]  = imm[4:1];
                pk[7]     = imm[11];
            end
            IMM_J: begin
                pk[31]    = imm[20];
                pk[30:21] = imm[10:1];
                pk[20]    = imm[11];
                pk[19:12] = imm[19:12];
            end
            IMM_U:   pk[31:12] = imm[31:12];
            default: ;
        endcase
    end

    // Prioritise errors and substitute a NOP for any rejected request
    always_comb begin
        ec = ERR_OK;
        if (illegal)      ec = ERR_ILLEGAL;
        else if (misal)   ec = ERR_MISAL;
        else if (!rng_ok) ec = ERR_RANGE;
        rsp.errcode = ec;
        rsp.err     = (ec != ERR_OK);
        rsp.instr   = (ec != ERR_OK) ? NOP_INSTR : pk;
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with saturating handshake counters.
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_immsrc,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [1:0]       out_errcode,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int STAGES = 2;

    logic [STAGES:1] vld_pipe;
    enc_req_t        s1_req;
    enc_rsp_t        pack_rsp;
    logic            adv1;
    logic            adv2;
    logic            hs;

    // A stage may load when it is empty or its contents move on this cycle
    assign adv2      = !vld_pipe[2] || out_ready;
    assign adv1      = !vld_pipe[1] || adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_pipe[2];
    assign hs        = vld_pipe[2] && out_ready;

    imm_pack u_pack (
        .req (s1_req),
        .rsp (pack_rsp)
    );

    // Pipeline registers: S1 captures the request, S2 captures the packed result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe    <= '0;
            s1_req      <= '0;
            out_instr   <= '0;
            out_err     <= 1'b0;
            out_errcode <= ERR_OK;
        end else begin
            if (adv1) begin
                vld_pipe[1] <= in_valid;
                if (in_valid)
                    s1_req <= '{immsrc: in_immsrc, imm: in_imm, base: in_base};
            end
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_instr   <= pack_rsp.instr;
                    out_err     <= pack_rsp.err;
                    out_errcode <= pack_rsp.errcode;
                end
            end
        end
    end

    // Saturating handshake counters; a clear beats a same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (clr_counts) begin
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (hs && (enc_count != '1))
                enc_count <= enc_count + CNT_W'(1);
            if (hs && out_err && (err_count != '1))
                err_count <= err_count + CNT_W'(1);
        end
    end

endmodule
